// File: rtl/qos_flow_fsm_if.sv
// qos_flow_fsm_if: groups the FIFO-bank control bus of qos_flow_fsm.
// Ports: master drives init, requested thresholds and per-FIFO status flags;
//        slave (the controller) returns thresholds, state, flags, pause, error record.
interface qos_flow_fsm_if #(
  parameter int LEN = 4,
  parameter int NF  = 4
);
  // requests and FIFO status into the controller
  logic           init;
  logic [LEN-1:0] umbral_bajo_in;
  logic [LEN-1:0] umbral_alto_in;
  logic [NF-1:0]  fifo_empty;
  logic [NF-1:0]  fifo_almost_full;
  logic [NF-1:0]  fifo_almost_empty;
  logic [NF-1:0]  fifo_error;
  // controller results
  logic [LEN-1:0] umbral_bajo_out;
  logic [LEN-1:0] umbral_alto_out;
  logic [2:0]     state;
  logic           idle_out;
  logic           active_out;
  logic           error_out;
  logic           cfg_bad;
  logic [NF-1:0]  pause_out;
  logic [NF-1:0]  error_fifo;
  logic           wd_timeout;

  modport master (
    output init, umbral_bajo_in, umbral_alto_in, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_error,
    input  umbral_bajo_out, umbral_alto_out, state, idle_out, active_out,
           error_out, cfg_bad, pause_out, error_fifo, wd_timeout
  );

  modport slave (
    input  init, umbral_bajo_in, umbral_alto_in, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_error,
    output umbral_bajo_out, umbral_alto_out, state, idle_out, active_out,
           error_out, cfg_bad, pause_out, error_fifo, wd_timeout
  );
endinterface

// File: rtl/qos_flow_fsm.sv
// qos_flow_fsm: QoS FIFO-bank controller; loads low/high thresholds, tracks INIT/IDLE/ACTIVE/ERROR,
//   drives per-FIFO pause with almost-full/almost-empty hysteresis. Latency: 1 cycle input-to-state,
//   Moore outputs (cfg_bad is combinational). Backpressure: pause_out asserted to writers, never stalls itself.
// Ports: clk, reset_L (async active-low), bus (qos_flow_fsm_if.slave: init, thresholds in/out,
//   fifo_* flags, state, idle/active/error flags, cfg_bad, pause_out, error_fifo, wd_timeout).
// Optional watchdog: define QOS_FSM_WDOG_EN to build the paused-too-long counter (WD_CYCLES).
module qos_flow_fsm #(
  parameter int LEN       = 4,
  parameter int NF        = 4,
  parameter int LOW_DEF   = 1,
  parameter int HIGH_DEF  = 3,
  parameter int WD_CYCLES = 16
) (
  input  logic           clk,
  input  logic           reset_L,
  qos_flow_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  if (WD_CYCLES < 1 || LOW_DEF >= HIGH_DEF) begin : g_bad_param
    $error("qos_flow_fsm: WD_CYCLES must be >= 1 and LOW_DEF < HIGH_DEF");
  end

  state_t         st, st_nxt;
  logic [LEN-1:0] lo_r, hi_r;
  logic [NF-1:0]  pause_r, pause_nxt;
  logic [NF-1:0]  efifo_r, efifo_nxt;
  logic           cfg_ok;
  logic           err_hit;
  logic           wd_fire;

  assign cfg_ok  = bus.umbral_bajo_in < bus.umbral_alto_in;
  assign err_hit = (|bus.fifo_error) | wd_fire;

  always_comb begin
    st_nxt    = st;
    pause_nxt = pause_r;
    efifo_nxt = efifo_r;

    case (st)
      S_RESET:  st_nxt = S_INIT;
      S_INIT:   if (!bus.init && cfg_ok) st_nxt = S_IDLE;
      S_IDLE: begin
        if (err_hit)                 st_nxt = S_ERROR;
        else if (bus.init)           st_nxt = S_INIT;
        else if (bus.fifo_empty != '1) st_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (err_hit)                 st_nxt = S_ERROR;
        else if (bus.init)           st_nxt = S_INIT;
        else if (bus.fifo_empty == '1) st_nxt = S_IDLE;
      end
      S_ERROR:  if (bus.init) st_nxt = S_INIT;
      default:  st_nxt = S_ERROR;
    endcase

    // pause is registered against the state being entered so it lines up with state.
    // Hysteresis: almost-full sets, almost-empty clears, set wins when both are high.
    case (st_nxt)
      S_IDLE:   pause_nxt = '0;
      S_ACTIVE: pause_nxt = (pause_r | bus.fifo_almost_full)
                            & ~(bus.fifo_almost_empty & ~bus.fifo_almost_full);
      default:  pause_nxt = '1;
    endcase

    // Error record: snapshot on entry to ERROR, accumulate while there, wipe on INIT.
    if (st_nxt == S_INIT)
      efifo_nxt = '0;
    else if (st_nxt == S_ERROR)
      efifo_nxt = (st == S_ERROR) ? (efifo_r | bus.fifo_error) : bus.fifo_error;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st      <= S_RESET;
      lo_r    <= LEN'(LOW_DEF);
      hi_r    <= LEN'(HIGH_DEF);
      pause_r <= '1;
      efifo_r <= '0;
    end else begin
      st      <= st_nxt;
      pause_r <= pause_nxt;
      efifo_r <= efifo_nxt;
      if (st == S_INIT && cfg_ok) begin
        lo_r <= bus.umbral_bajo_in;
        hi_r <= bus.umbral_alto_in;
      end
    end
  end

`ifdef QOS_FSM_WDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);

  logic [WDW-1:0] wd_cnt, wd_cnt_nxt;
  logic           wd_to_r;

  // Counts ACTIVE cycles spent with any pause asserted; fires on the edge that
  // completes the WD_CYCLES-th such cycle, so that edge already moves to ERROR.
  always_comb begin
    wd_cnt_nxt = '0;
    if (st == S_ACTIVE && (|pause_r) && wd_cnt != WDW'(WD_CYCLES))
      wd_cnt_nxt = wd_cnt + 1'b1;
  end

  assign wd_fire = (st == S_ACTIVE) && (wd_cnt_nxt == WDW'(WD_CYCLES));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wd_cnt  <= '0;
      wd_to_r <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      if (st_nxt == S_INIT) wd_to_r <= 1'b0;
      else if (wd_fire)     wd_to_r <= 1'b1;
    end
  end

  assign bus.wd_timeout = wd_to_r;
`else
  assign wd_fire        = 1'b0;
  assign bus.wd_timeout = 1'b0;
`endif

  assign bus.umbral_bajo_out = lo_r;
  assign bus.umbral_alto_out = hi_r;
  assign bus.state           = st;
  assign bus.idle_out        = (st == S_IDLE);
  assign bus.active_out      = (st == S_ACTIVE);
  assign bus.error_out       = (st == S_ERROR);
  assign bus.cfg_bad         = (st == S_INIT) && !cfg_ok;
  assign bus.pause_out       = pause_r;
  assign bus.error_fifo      = efifo_r;

endmodule
